// File: rtl/power_pack_scheduler_pkg.sv
// Shared definitions for the power pack scheduler: mode codes, FSM states,
// LFSR tap mask and the small helpers built on them.
package power_pack_scheduler_pkg;

    // Pack / effect mode codes, shared with power_pack2
    localparam logic [1:0] MODE_SHRINK = 2'b00;
    localparam logic [1:0] MODE_BOOST  = 2'b01;
    localparam logic [1:0] MODE_SHIELD = 2'b11;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT     = 2'b01,
        ST_ON_FIELD = 2'b10,
        ST_COOL     = 2'b11
    } sched_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // 2'b10 is not a legal pack mode; fold it onto SHIELD
    function automatic logic [1:0] draw_mode(input logic [1:0] bits);
        return (bits == 2'b10) ? MODE_SHIELD : bits;
    endfunction

endpackage

// File: rtl/power_pack_scheduler_fx_timer.sv
// Per-player effect timer: a pickup loads the mode and a full frame budget,
// frames count it down, and the effect ends on the frame that empties it.
module power_pack_scheduler_fx_timer #(
    parameter int EFFECT_FRAMES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [1:0] mode_i,
    input  logic       frame_tick_i,
    output logic       active_o,
    output logic [1:0] mode_o
);
    localparam int CW = (EFFECT_FRAMES < 1) ? 1 : $clog2(EFFECT_FRAMES + 1);
    localparam logic [CW-1:0] EFF_CNT = CW'(EFFECT_FRAMES);

    logic          active_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] count_q;

    // Clear beats load beats countdown; a reload ignores a coincident frame tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            mode_q   <= 2'b00;
            count_q  <= '0;
        end else if (clear_i) begin
            active_q <= 1'b0;
            mode_q   <= 2'b00;
            count_q  <= '0;
        end else if (load_i) begin
            active_q <= (EFFECT_FRAMES != 0);
            mode_q   <= mode_i;
            count_q  <= EFF_CNT;
        end else if (frame_tick_i && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    assign active_o = active_q;
    assign mode_o   = mode_q;

endmodule

// File: rtl/power_pack_scheduler.sv
// Power pack sequencer for Pong: spawn timing and placement, pickup and
// timeout handling, and routing of the timed effect to the right player.
module power_pack_scheduler
    import power_pack_scheduler_pkg::*;
#(
    parameter int          SPAWN_DELAY   = 300,
    parameter int          FIELD_TIMEOUT = 600,
    parameter int          EFFECT_FRAMES = 480,
    parameter int          COOLDOWN      = 120,
    parameter logic [10:0] X_MIN         = 11'd128,
    parameter logic [9:0]  Y_MIN         = 10'd64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_active,
    input  logic        frame_tick,
    input  logic        eaten,
    input  logic        last_hit,
    output logic        spawn,
    output logic        despawn,
    output logic [10:0] randx,
    output logic [9:0]  randy,
    output logic [1:0]  mode,
    output logic        p1_fx_active,
    output logic [1:0]  p1_fx_mode,
    output logic        p2_fx_active,
    output logic [1:0]  p2_fx_mode
);
    localparam int MAX_SF = (SPAWN_DELAY > FIELD_TIMEOUT) ? SPAWN_DELAY : FIELD_TIMEOUT;
    localparam int MAX_P  = (MAX_SF > COOLDOWN) ? MAX_SF : COOLDOWN;
    localparam int CW     = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

    localparam logic [CW-1:0] SPAWN_CNT = CW'(SPAWN_DELAY);
    localparam logic [CW-1:0] FIELD_CNT = CW'(FIELD_TIMEOUT);
    localparam logic [CW-1:0] COOL_CNT  = CW'(COOLDOWN);

    sched_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   lfsr_q;
    logic          eaten_q;
    logic          spawn_pend_q;
    logic          spawn_q;
    logic          despawn_q;
    logic [10:0]   randx_q;
    logic [9:0]    randy_q;
    logic [1:0]    mode_q;

    logic          pickup;
    logic          expiry;
    logic [CW-1:0] cnt_dec;
    logic          target_p2;

    // Pickups only count while a pack is on the field and play is live
    assign pickup    = eaten && !eaten_q && (state_q == ST_ON_FIELD) && game_active;
    // The phase counter ends on the frame that would take it to zero (or if it is already zero)
    assign expiry    = (cnt_q == '0) || (frame_tick && (cnt_q == CW'(1)));
    assign cnt_dec   = (frame_tick && (cnt_q != '0)) ? cnt_q - CW'(1) : cnt_q;
    // SHRINK hurts the opponent; BOOST and SHIELD help whoever last hit the ball
    assign target_p2 = (mode_q == MODE_SHRINK) ? !last_hit : last_hit;

    // Free-running LFSR and eaten edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= LFSR_SEED;
            eaten_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_step(lfsr_q);
            eaten_q <= eaten;
        end
    end

    // Spawn/withdraw sequencing with registered pulse and placement outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            spawn_pend_q <= 1'b0;
            spawn_q      <= 1'b0;
            despawn_q    <= 1'b0;
            randx_q      <= X_MIN;
            randy_q      <= Y_MIN;
            mode_q       <= MODE_SHRINK;
        end else begin
            // spawn trails the placement registers by one cycle so they are settled
            spawn_q      <= spawn_pend_q && game_active;
            spawn_pend_q <= 1'b0;
            despawn_q    <= 1'b0;
            if (!game_active) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                despawn_q <= (state_q == ST_ON_FIELD);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_WAIT;
                        cnt_q   <= SPAWN_CNT;
                    end
                    ST_WAIT: begin
                        if (expiry) begin
                            state_q      <= ST_ON_FIELD;
                            cnt_q        <= FIELD_CNT;
                            randx_q      <= X_MIN + {2'b00, lfsr_q[8:0]};
                            randy_q      <= Y_MIN + {1'b0, lfsr_q[15:8], 1'b0};
                            mode_q       <= draw_mode(lfsr_q[1:0]);
                            spawn_pend_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_dec;
                        end
                    end
                    ST_ON_FIELD: begin
                        if (pickup) begin
                            state_q <= ST_COOL;
                            cnt_q   <= COOL_CNT;
                        end else if (expiry) begin
                            state_q   <= ST_COOL;
                            cnt_q     <= COOL_CNT;
                            despawn_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_dec;
                        end
                    end
                    ST_COOL: begin
                        if (expiry) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= SPAWN_CNT;
                        end else begin
                            cnt_q <= cnt_dec;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    power_pack_scheduler_fx_timer #(
        .EFFECT_FRAMES (EFFECT_FRAMES)
    ) u_fx_p1 (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (!game_active),
        .load_i       (pickup && !target_p2),
        .mode_i       (mode_q),
        .frame_tick_i (frame_tick),
        .active_o     (p1_fx_active),
        .mode_o       (p1_fx_mode)
    );

    power_pack_scheduler_fx_timer #(
        .EFFECT_FRAMES (EFFECT_FRAMES)
    ) u_fx_p2 (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (!game_active),
        .load_i       (pickup && target_p2),
        .mode_i       (mode_q),
        .frame_tick_i (frame_tick),
        .active_o     (p2_fx_active),
        .mode_o       (p2_fx_mode)
    );

    assign spawn   = spawn_q;
    assign despawn = despawn_q;
    assign randx   = randx_q;
    assign randy   = randy_q;
    assign mode    = mode_q;

endmodule

// File: tb/tb_power_pack_scheduler.sv
// Directed bench for power_pack_scheduler. A second instance with a longer
// effect budget shares every input so effect reloads can be observed while
// the main instance runs at the reference parameters.
module tb_power_pack_scheduler;

    logic        clk = 1'b0;
    logic        reset, game_active, frame_tick, eaten, last_hit;

    logic        spawn, despawn, p1a, p2a;
    logic [10:0] randx;
    logic [9:0]  randy;
    logic [1:0]  mode, p1m, p2m;

    logic        s2_spawn, s2_despawn, s2_p1a, s2_p2a;
    logic [10:0] s2_randx;
    logic [9:0]  s2_randy;
    logic [1:0]  s2_mode, s2_p1m, s2_p2m;

    int total = 0;
    int bad = 0;
    int spawn_cnt = 0;
    int despawn_cnt = 0;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    power_pack_scheduler #(
        .SPAWN_DELAY(3), .FIELD_TIMEOUT(5), .EFFECT_FRAMES(4), .COOLDOWN(2)
    ) u_dut (
        .clk(clk), .reset(reset), .game_active(game_active), .frame_tick(frame_tick),
        .eaten(eaten), .last_hit(last_hit), .spawn(spawn), .despawn(despawn),
        .randx(randx), .randy(randy), .mode(mode),
        .p1_fx_active(p1a), .p1_fx_mode(p1m), .p2_fx_active(p2a), .p2_fx_mode(p2m)
    );

    power_pack_scheduler #(
        .SPAWN_DELAY(3), .FIELD_TIMEOUT(5), .EFFECT_FRAMES(6), .COOLDOWN(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .game_active(game_active), .frame_tick(frame_tick),
        .eaten(eaten), .last_hit(last_hit), .spawn(s2_spawn), .despawn(s2_despawn),
        .randx(s2_randx), .randy(s2_randy), .mode(s2_mode),
        .p1_fx_active(s2_p1a), .p1_fx_mode(s2_p1m), .p2_fx_active(s2_p2a), .p2_fx_mode(s2_p2m)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Pulse counters, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (spawn)   spawn_cnt++;
        if (despawn) despawn_cnt++;
    end

    function automatic logic [1:0] map_mode(input logic [1:0] b);
        return (b == 2'b10) ? 2'b11 : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    // pre plain frames, then hold in WAIT until the LFSR will draw 'want', then the spawning frame
    task automatic spawn_with(input logic [1:0] want, input bit any, input int pre);
        int sc0;
        int n;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic [1:0]  em;
        sc0 = spawn_cnt;
        for (int i = 0; i < pre; i++) tick();
        n = 0;
        while (!any && (map_mode(lfsr_m[1:0]) != want) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("mode_wait", 0, 1);
        chk("no_early_spawn", spawn_cnt, sc0);
        ex = 11'd128 + {2'b00, lfsr_m[8:0]};
        ey = 10'd64 + {1'b0, lfsr_m[15:8], 1'b0};
        em = map_mode(lfsr_m[1:0]);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("randx", randx, ex);
        chk("randy", randy, ey);
        chk("mode", mode, em);
        chk("spawn_lag", spawn, 0);
        @(negedge clk);
        chk("spawn", spawn, 1);
        @(negedge clk);
        chk("spawn_len", spawn, 0);
        chk("spawn_cnt", spawn_cnt, sc0 + 1);
    endtask

    task automatic pick(input logic lh);
        last_hit = lh;
        eaten = 1'b1;
        @(negedge clk);
        eaten = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        reset = 1'b0; game_active = 1'b0; frame_tick = 1'b0; eaten = 1'b0; last_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_spawn", spawn, 0);
        chk("rst_despawn", despawn, 0);
        chk("rst_randx", randx, 128);
        chk("rst_randy", randy, 64);
        chk("rst_mode", mode, 0);
        chk("rst_p1", {p1a, p1m}, 0);
        chk("rst_p2", {p2a, p2m}, 0);

        reset = 1'b1; game_active = 1'b1;
        @(negedge clk);

        // 1: first spawn after three frames
        spawn_with(2'b01, 1'b0, 2);
        chk("rx_range", (randx >= 11'd128) && (randx <= 11'd639), 1);
        chk("ry_range", (randy >= 10'd64) && (randy <= 10'd574), 1);
        chk("mode_ne10", mode != 2'b10, 1);

        // 2: BOOST picked by P1, lasts exactly four frames
        pick(1'b0);
        chk("t2_p1a", p1a, 1);
        chk("t2_p1m", p1m, 2'b01);
        chk("t2_p2a", p2a, 0);
        repeat (3) tick();
        chk("t2_p1a_3", p1a, 1);
        tick();
        chk("t2_p1a_4", p1a, 0);
        chk("t2_nodesp", despawn_cnt, 0);

        // 3: SHRINK picked by P1 lands on P2
        spawn_with(2'b00, 1'b0, 0);
        pick(1'b0);
        chk("t3_p2a", p2a, 1);
        chk("t3_p2m", p2m, 2'b00);
        chk("t3_p1a", p1a, 0);

        // 4: timeout withdraws the pack, next spawn 2+3 frames later
        spawn_with(2'b11, 1'b0, 4);
        repeat (4) tick();
        chk("t4_desp_4", despawn_cnt, 0);
        tick();
        chk("t4_desp_5", despawn_cnt, 1);
        spawn_with(2'b01, 1'b0, 4);

        // 5: pickup on the timeout frame wins; coincident frame does not shorten the effect
        repeat (4) tick();
        last_hit = 1'b0; eaten = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        eaten = 1'b0; frame_tick = 1'b0;
        chk("t5_p1a", p1a, 1);
        chk("t5_p1m", p1m, 2'b01);
        @(negedge clk);
        chk("t5_desp", despawn, 0);
        chk("t5_desp_cnt", despawn_cnt, 1);
        repeat (3) tick();
        chk("t5_p1a_3", p1a, 1);
        tick();
        chk("t5_p1a_4", p1a, 0);
        chk("t5_s2_p1a", s2_p1a, 1);

        // 5b: re-pick while the long-budget P1 effect has one frame left
        spawn_with(2'b01, 1'b0, 0);
        chk("t5b_s2_pre", s2_p1a, 1);
        pick(1'b0);
        repeat (4) tick();
        chk("t5b_p1a", p1a, 0);
        chk("t5b_s2_p1a", s2_p1a, 1);

        // 6: P2 active while a pack is on the field, then play stops
        spawn_with(2'b00, 1'b0, 0);
        pick(1'b0);
        tick();
        chk("t6_s2_p1_end", s2_p1a, 0);
        spawn_with(2'b00, 1'b1, 3);
        chk("t6_s2_p2a", s2_p2a, 1);
        game_active = 1'b0;
        @(negedge clk);
        chk("t6_desp", despawn, 1);
        chk("t6_s2_desp", s2_despawn, 1);
        chk("t6_s2_fx", {s2_p1a, s2_p2a}, 0);
        chk("t6_fx", {p1a, p2a}, 0);
        @(negedge clk);
        chk("t6_desp_len", despawn, 0);
        sc = spawn_cnt;
        repeat (4) tick();
        chk("t6_idle_nospawn", spawn_cnt, sc);
        chk("t6_desp_total", despawn_cnt, 2);

        // reset mid-WAIT
        game_active = 1'b1;
        @(negedge clk);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("mr_randx", randx, 128);
        chk("mr_randy", randy, 64);
        chk("mr_mode", mode, 0);
        chk("mr_pulses", {spawn, despawn}, 0);
        chk("mr_fx", {p1a, p1m, p2a, p2m}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        spawn_with(2'b00, 1'b1, 2);
        chk("mr_desp_total", despawn_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
